// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes and FSM states.
package load_store_unit_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] LSU_F3_B  = 3'b000;
   localparam logic [2:0] LSU_F3_H  = 3'b001;
   localparam logic [2:0] LSU_F3_W  = 3'b010;
   localparam logic [2:0] LSU_F3_BU = 3'b100;
   localparam logic [2:0] LSU_F3_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_ST_IDLE = 2'd0,
      LSU_ST_REQ  = 2'd1,
      LSU_ST_DONE = 2'd2
   } lsu_state_e;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational lane logic: byte enables, store-data replication, legality check,
// and extraction/extension of the returned load word.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]      funct3_i,
   input  logic [1:0]      addr_lo_i,
   input  logic            is_store_i,
   input  logic [XLEN-1:0] st_data_i,
   input  logic [2:0]      ld_funct3_i,
   input  logic [1:0]      ld_lo_i,
   input  logic [XLEN-1:0] rd_data_i,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic            bad_o,
   output logic [XLEN-1:0] ld_data_o
);

   logic [XLEN-1:0] shifted;
   logic [15:0]     half;

   always_comb begin
      be_o    = 4'b0000;
      wdata_o = '0;
      bad_o   = 1'b1;
      unique case (funct3_i)
         LSU_F3_B, LSU_F3_BU: begin
            be_o    = 4'b0001 << addr_lo_i;
            wdata_o = {4{st_data_i[7:0]}};
            bad_o   = is_store_i && (funct3_i == LSU_F3_BU);
         end
         LSU_F3_H, LSU_F3_HU: begin
            be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_o = {2{st_data_i[15:0]}};
            bad_o   = addr_lo_i[0] || (is_store_i && (funct3_i == LSU_F3_HU));
         end
         LSU_F3_W: begin
            be_o    = 4'b1111;
            wdata_o = st_data_i;
            bad_o   = (addr_lo_i != 2'b00);
         end
         default: bad_o = 1'b1;
      endcase
   end

   // Byte lane is brought down to bit 0 before extension.
   assign shifted = rd_data_i >> {ld_lo_i, 3'b000};
   assign half    = ld_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];

   always_comb begin
      ld_data_o = '0;
      unique case (ld_funct3_i)
         LSU_F3_B:  ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
         LSU_F3_BU: ld_data_o = {24'h0, shifted[7:0]};
         LSU_F3_H:  ld_data_o = {{16{half[15]}}, half};
         LSU_F3_HU: ld_data_o = {16'h0, half};
         LSU_F3_W:  ld_data_o = rd_data_i;
         default:   ld_data_o = '0;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: issues one word-aligned bus request per load/store,
// waits for ack with a timeout, and returns the extended load result.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic [DWIDTH-1:0] LSU_Addr,
   input  logic [DWIDTH-1:0] LSU_Store_Data,
   input  logic [2:0]        LSU_Funct3,
   input  logic              LSU_Load,
   input  logic              LSU_Store,
   output logic [DWIDTH-1:0] LSU_Load_Data,
   output logic              LSU_Done,
   output logic              LSU_Stall,
   output logic              LSU_Fault,
   output logic              Mem_Req,
   output logic              Mem_We,
   output logic [DWIDTH-1:0] Mem_Addr,
   output logic [3:0]        Mem_Be,
   output logic [DWIDTH-1:0] Mem_Wdata,
   input  logic              Mem_Ack,
   input  logic [DWIDTH-1:0] Mem_Rdata
);

   localparam int            CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   lsu_state_e        state_q, state_d;
   logic [CW-1:0]     cnt_q;
   logic              we_q, tmo_q, flt_q;
   logic [DWIDTH-1:2] addr_q;
   logic [1:0]        lo_q;
   logic [2:0]        f3_q;
   logic [3:0]        be_q;
   logic [DWIDTH-1:0] wdata_q, ld_q;

   logic [3:0]        be_c;
   logic [DWIDTH-1:0] wdata_c, ld_ext;
   logic              bad_c, one_op, idle, accept, reject;

   lsu_align u_align (
      .funct3_i    (LSU_Funct3),
      .addr_lo_i   (LSU_Addr[1:0]),
      .is_store_i  (LSU_Store),
      .st_data_i   (LSU_Store_Data),
      .ld_funct3_i (f3_q),
      .ld_lo_i     (lo_q),
      .rd_data_i   (Mem_Rdata),
      .be_o        (be_c),
      .wdata_o     (wdata_c),
      .bad_o       (bad_c),
      .ld_data_o   (ld_ext)
   );

   assign one_op = LSU_Load ^ LSU_Store;
   assign idle   = (state_q == LSU_ST_IDLE);
   assign accept = idle && !Rst && one_op && !bad_c;
   assign reject = idle && ((LSU_Load && LSU_Store) || (one_op && bad_c));

   always_ff @(posedge Clk) begin
      if (Rst) state_q <= LSU_ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         LSU_ST_IDLE: if (accept) state_d = LSU_ST_REQ;
         LSU_ST_REQ:  if (Mem_Ack || (cnt_q == TMO_LAST)) state_d = LSU_ST_DONE;
         LSU_ST_DONE: state_d = LSU_ST_IDLE;
         default:     state_d = LSU_ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q   <= '0;
         we_q    <= 1'b0;
         tmo_q   <= 1'b0;
         flt_q   <= 1'b0;
         addr_q  <= '0;
         lo_q    <= 2'b00;
         f3_q    <= 3'b000;
         be_q    <= 4'b0000;
         wdata_q <= '0;
         ld_q    <= '0;
      end else begin
         flt_q <= reject;
         if (accept) begin
            we_q    <= LSU_Store;
            addr_q  <= LSU_Addr[DWIDTH-1:2];
            lo_q    <= LSU_Addr[1:0];
            f3_q    <= LSU_Funct3;
            be_q    <= be_c;
            wdata_q <= wdata_c;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            ld_q    <= '0;
         end else if (state_q == LSU_ST_REQ) begin
            // An ack on the final allowed cycle still completes cleanly.
            if (Mem_Ack) begin
               if (!we_q) ld_q <= ld_ext;
            end else if (cnt_q == TMO_LAST) begin
               tmo_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      LSU_Stall     = accept || (state_q == LSU_ST_REQ);
      LSU_Done      = (state_q == LSU_ST_DONE);
      LSU_Fault     = flt_q || ((state_q == LSU_ST_DONE) && tmo_q);
      LSU_Load_Data = (state_q == LSU_ST_DONE) ? ld_q : '0;
      Mem_Req       = (state_q == LSU_ST_REQ);
      Mem_We        = Mem_Req && we_q;
      Mem_Addr      = Mem_Req ? {addr_q, 2'b00} : '0;
      Mem_Be        = Mem_Req ? be_q : 4'b0000;
      Mem_Wdata     = Mem_Req ? wdata_q : '0;
   end

endmodule
